// File: rtl/reg_bank_p.sv
// Multi-ported flop register bank: byte-lane writes, two registered write-first read ports,
// and a sequential clear engine that zeroes one register per cycle.
module reg_bank_p #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned AW      = 3,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   din,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   dout_a,
    output logic [WIDTH-1:0]   dout_b,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic               clr_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned NB    = WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    ptr_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] dout_a_q;
    logic [WIDTH-1:0] dout_b_q;
    logic             wr_acc;

    // Writes are dropped, not queued, while the clear engine owns the array.
    assign wr_acc = we && !busy_q;

    // regs_d is the array content after the coming edge; reads sample it to get write-first.
    always_comb begin
        regs_d = regs_q;
        if (wr_acc && !(ZERO_R0 != 0 && waddr == '0)) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wbe[b]) begin
                    regs_d[waddr][8*b +: 8] = din[8*b +: 8];
                end
            end
        end
        if (state_q == StClear) begin
            regs_d[ptr_q] = '0;
        end
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            regs_q   <= regs_d;
            dout_a_q <= regs_d[raddr_a];
            dout_b_q <= regs_d[raddr_b];
        end
    end

    // Clear sequencer; busy/done are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= StDone;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout_a   = dout_a_q;
    assign dout_b   = dout_b_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_reg_bank_p.sv
// Scoreboard bench for reg_bank_p: a reference model pushes expected outputs per driven cycle,
// which are popped and compared one step after the corresponding clock edge.
`timescale 1ns/1ps
module tb_reg_bank_p;

    localparam int WIDTH = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] din;
    logic [1:0]       wbe;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] dout_a;
    logic [WIDTH-1:0] dout_b;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    reg_bank_p #(.WIDTH(WIDTH), .AW(AW), .ZERO_R0(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .din      (din),
        .wbe      (wbe),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .dout_a   (dout_a),
        .dout_b   (dout_b),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: 0 idle, 1 clearing, 2 done.
    logic [WIDTH-1:0] m_regs [DEPTH];
    int               m_state;
    int               m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_state = 0;
        m_ptr   = 0;
    endtask

    // Evaluate the model for the current inputs, push the expectation, clock, then compare.
    task automatic step(input string tag);
        exp_t e;
        if (we && m_state != 1 && waddr != 0) begin
            if (wbe[0]) m_regs[waddr][7:0]  = din[7:0];
            if (wbe[1]) m_regs[waddr][15:8] = din[15:8];
        end
        if (m_state == 1) m_regs[m_ptr] = '0;
        case (m_state)
            0: if (clr_req) begin m_state = 1; m_ptr = 0; end
            1: if (m_ptr == DEPTH - 1) begin m_state = 2; m_ptr = 0; end else m_ptr++;
            default: m_state = 0;
        endcase
        e.a    = m_regs[raddr_a];
        e.b    = m_regs[raddr_b];
        e.busy = (m_state == 1);
        e.done = (m_state == 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = q.pop_front();
            check({tag, "_dout_a"}, 64'(dout_a), 64'(e.a));
            check({tag, "_dout_b"}, 64'(dout_b), 64'(e.b));
            check({tag, "_busy"}, 64'(clr_busy), 64'(e.busy));
            check({tag, "_done"}, 64'(clr_done), 64'(e.done));
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; din = '0; wbe = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    endtask

    int nbusy;
    int ndone;

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout_a", 64'(dout_a), 64'd0);
        check("reset_dout_b", 64'(dout_b), 64'd0);
        check("reset_busy", 64'(clr_busy), 64'd0);
        check("reset_done", 64'(clr_done), 64'd0);
        rst = 1'b1;

        // Full write with same-cycle read.
        we = 1; waddr = 3; din = 16'hA5C3; wbe = 2'b11; raddr_a = 3;
        step("full_wr");
        check("full_wr_const", 64'(dout_a), 64'hA5C3);

        // Low lane only, port B reads the merged value.
        din = 16'h1234; wbe = 2'b01; raddr_b = 3;
        step("lane_wr");
        check("lane_wr_const", 64'(dout_b), 64'hA534);

        // Register 0 is hardwired to zero.
        waddr = 0; din = 16'hFFFF; wbe = 2'b11; raddr_a = 0;
        step("r0_wr");
        check("r0_const", 64'(dout_a), 64'h0000);

        // Random traffic, including high-lane-only writes.
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1)); waddr = AW'($urandom);
            din = WIDTH'($urandom); wbe = 2'($urandom);
            raddr_a = AW'($urandom); raddr_b = (i % 4 == 0) ? raddr_a : AW'($urandom);
            step("rand");
        end

        // Fill 1..7; the last write coincides with clr_req.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; waddr = AW'(i); din = 16'h1111 * WIDTH'(i); wbe = 2'b11;
            raddr_a = AW'(i); raddr_b = AW'(i);
            clr_req = (i == DEPTH - 1);
            step("fill");
        end
        check("fill7_const", 64'(dout_a), 64'h7777);

        // Clear sequence with writes attempted throughout.
        clr_req = 0; nbusy = (clr_busy === 1'b1) ? 1 : 0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            we = 1; waddr = AW'(i % DEPTH + 1); din = 16'hDEAD; wbe = 2'b11;
            raddr_a = AW'(i % DEPTH); raddr_b = AW'((i + 1) % DEPTH);
            if (i == 9) we = 0;
            step("clear");
            if (clr_busy === 1'b1) nbusy++;
            if (clr_done === 1'b1) ndone++;
        end
        check("busy_cycles", 64'(nbusy), 64'd8);
        check("done_cycles", 64'(ndone), 64'd1);

        we = 0;
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = AW'(i); raddr_b = AW'(DEPTH - 1 - i);
            step("post_clear");
        end

        // Refill, then hold clr_req high so the level restarts a clear after DONE.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; waddr = AW'(i); din = 16'hA000 | WIDTH'(i); wbe = 2'b11;
            raddr_a = AW'(i); raddr_b = 0;
            step("refill");
        end
        we = 0; clr_req = 1;
        for (int i = 0; i < 12; i++) begin
            raddr_a = AW'(i % DEPTH); raddr_b = AW'(i % DEPTH);
            step("level_req");
        end
        clr_req = 0;
        for (int i = 0; i < 10; i++) step("drain");

        // Abort a clear with an async reset pulse mid-sequence.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1; waddr = AW'(i); din = 16'h5A00 | WIDTH'(i); wbe = 2'b11;
            raddr_a = AW'(i); raddr_b = AW'(i);
            step("pre_abort");
        end
        we = 0; clr_req = 1; raddr_a = 7; raddr_b = 6;
        step("abort_start");
        clr_req = 0;
        repeat (3) step("abort_run");
        #3;
        rst = 1'b0;
        #1;
        check("abort_dout_a", 64'(dout_a), 64'd0);
        check("abort_dout_b", 64'(dout_b), 64'd0);
        check("abort_busy", 64'(clr_busy), 64'd0);
        check("abort_done", 64'(clr_done), 64'd0);
        rst = 1'b1;
        model_reset();
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            raddr_a = AW'(i % DEPTH); raddr_b = 7;
            step("after_abort");
            if (clr_done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        we = 1; waddr = 2; din = 16'hBEEF; wbe = 2'b11; raddr_a = 2; raddr_b = 2;
        step("resume_wr");
        check("resume_const_a", 64'(dout_a), 64'hBEEF);
        check("resume_const_b", 64'(dout_b), 64'hBEEF);
        we = 0;
        step("resume_hold");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_bank_p.md
REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits; legal values are multiples of 8, 8..64.
REQ-002 SHALL have parameter AW, default 3, address width; DEPTH = 2**AW registers.
REQ-003 SHALL have parameter ZERO_R0, default 1; 1 = register 0 reads as zero and ignores writes.
REQ-004 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port we  input  1  write request.
REQ-007 SHALL have port waddr  input  AW  write address.
REQ-008 SHALL have port din  input  WIDTH  write data.
REQ-009 SHALL have port wbe  input  WIDTH/8  byte-lane write enables; bit i covers din[8i+7:8i].
REQ-010 SHALL have port raddr_a  input  AW  read port A address.
REQ-011 SHALL have port raddr_b  input  AW  read port B address.
REQ-012 SHALL have port dout_a  output  WIDTH  registered read data, port A.
REQ-013 SHALL have port dout_b  output  WIDTH  registered read data, port B.
REQ-014 SHALL have port clr_req  input  1  request to clear all registers.
REQ-015 SHALL have port clr_busy  output  1  high while the clear sequence runs.
REQ-016 SHALL have port clr_done  output  1  one-cycle pulse at clear completion.

Function
REQ-017 Storage SHALL be DEPTH x WIDTH flops; no RAM inference is required.
REQ-018 A write SHALL be accepted on a rising edge when we=1 and clr_busy=0; only byte lanes with wbe=1 update, all other lanes hold.
REQ-019 With ZERO_R0=1, a write to address 0 SHALL have no effect, and reads of address 0 SHALL return 0.
REQ-020 Reads SHALL have 1-cycle latency: dout_x after edge N equals the content of raddr_x as it stands after edge N.
REQ-021 The read path SHALL be write-first: an accepted write to the same address in the same cycle returns the byte-merged new value.
REQ-022 Both read ports SHALL operate independently every cycle, including during clear; equal addresses on A and B SHALL return equal data.
REQ-023 The clear FSM SHALL have three states: IDLE, CLEAR, DONE.
REQ-024 In IDLE, clr_req=1 at an edge SHALL move the FSM to CLEAR with the pointer set to 0.
REQ-025 In CLEAR, each edge SHALL zero reg[ptr] and increment ptr; at the edge where ptr=DEPTH-1, the FSM SHALL move to DONE.
REQ-026 In DONE, the FSM SHALL return to IDLE on the next edge.
REQ-027 clr_busy SHALL be 1 exactly while in CLEAR, i.e. DEPTH cycles; clr_done SHALL be 1 exactly while in DONE.
REQ-028 clr_req SHALL be ignored in CLEAR and DONE; a level still high in IDLE starts a new clear.
REQ-029 A write and clr_req in the same IDLE cycle: the write SHALL be accepted, and the clear starts on the next cycle and zeroes that register.
REQ-030 we=1 while clr_busy=1 SHALL be dropped silently, with no queuing.
REQ-031 A read of the register being zeroed on an edge SHALL return 0, consistent with write-first.

Reset
REQ-032 rst=0 SHALL, asynchronously, zero all registers, dout_a and dout_b; clr_busy=0, clr_done=0, FSM=IDLE, ptr=0.
REQ-033 Assertion mid-clear SHALL abort the sequence with no clr_done pulse; operation resumes on the first edge after rst=1.

Verification
REQ-034 Reset, then we=1 waddr=3 din=16'hA5C3 wbe=2'b11, raddr_a=3 -> dout_a=16'hA5C3 after the same edge.
REQ-035 reg3=16'hA5C3, write din=16'h1234 wbe=2'b01 with raddr_b=3 -> dout_b=16'hA534 after the edge.
REQ-036 ZERO_R0=1, write 16'hFFFF to address 0, raddr_a=0 -> dout_a=16'h0000.
REQ-037 Fill regs 1..7 with nonzero data, pulse clr_req -> clr_busy high for 8 cycles, clr_done high for 1 cycle, all reads 0; we during busy has no effect.
REQ-038 rst=0 for 1 ns at cycle 3 of a clear -> all outputs 0 immediately, no clr_done pulse; a subsequent write/read works normally.
